lcg_mult_step: RTL
==================

Name: lcg_mult_step

Overview:
- Sequential multiply-accumulate stage for the MDCLCG generator: computes one LCG step, x_next = (A*x + C) mod 2^64.
- Shift-and-add over the bits of A. Each partial product x<<i comes from the existing 64-bit Barrel_shifter, which this block feeds with x and a 6-bit shift index and whose output it consumes.
- Sits between the generator state register and the Barrel_shifter.

Parameters:
- WIDTH, 64, datapath width; fixed by the 64-bit Barrel_shifter.
- SHIFT_W, 6, shift-index width, log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a_in  in  64  multiplier A.
- x_in  in  64  current LCG state x.
- c_in  in  64  increment C.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  64  x_next; holds until the next done.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, result=0, state=IDLE, idx=0, acc=0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 at edge k: capture a_reg=a_in, x_reg=x_in, acc=c_in, idx=0.
  - Go to RUN; busy=1 from edge k.
- RUN, each edge:
  - term = a_reg[idx] ? Barrel_shifter(x_reg, idx) : 0.
  - acc <= acc + term, truncated to 64 bits; carry-out discarded.
  - idx <= idx+1.
- Completion:
  - On the edge where idx==63: result <= acc+term, done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high during the cycle after edge k+64, i.e. 64 edges after the start edge.
- done is high for exactly one cycle.
- A start in the done cycle is accepted, giving back-to-back operation. The next done comes 64 edges later.
- start while busy=1 is ignored. It is neither queued nor able to corrupt the captured operands.
- Input operands may change freely after the start edge.
- Arithmetic is modulo 2^64 throughout; idx wraps only through completion.
- rst_n asserted mid-RUN: immediate return to the reset values. The partial result is discarded; no done.

Optional Feature:
- Macro: LCG_MULT_SKIP_ZERO_EN.
- Defined:
  - RUN processes the lowest set bit of a_rem (initialised to a_reg) each edge, then clears that bit.
  - Completes on the edge where the cleared a_rem becomes 0.
  - If A==0, completes on the first RUN edge with result=C.
  - Latency = max(popcount(A),1) edges after the start edge.
- Undefined: fixed 64-edge latency as specified above.
- Results are identical in both modes.

Decomposition:
- Package lcg_pkg holds:
  - WIDTH and SHIFT_W constants.
  - The state enum (IDLE, RUN).
- Reuse the existing Barrel_shifter for the partial product.
- Skip mode only: one sub-module, lcg_lsb_index. It is a combinational 64-bit lowest-set-bit priority encoder producing a 6-bit index and an all-zero flag.

Test Plan:
- A=3, x=5, C=7 -> result=22; done exactly 64 edges after the start edge (skip mode: 2 edges); busy low in the done cycle.
- A=0, x=0x1234, C=0x55 -> result=0x55 (skip mode: latency 1).
- Wrap-around:
  - A=0xFFFFFFFFFFFFFFFF, x=1, C=0 -> 0xFFFFFFFFFFFFFFFF.
  - A=0x8000000000000000, x=2, C=1 -> 1.
- Start pulsed again with different operands 10 cycles after the first accepted start -> ignored; result matches the first operands only; exactly one done.
- Back-to-back:
  - Start asserted in the done cycle with A=5, x=3, C=0 -> accepted; second done with result=15.
  - Random A/x/C over 1000 runs match a reference model mod 2^64.
- rst_n pulsed low at cycle 30 of RUN -> busy=0, done=0, result=0 immediately; no done follows; the next start computes correctly.

Source files
------------

// File: rtl/lcg_pkg.sv
// Shared constants and FSM encoding for the LCG multiply-accumulate step.
// Optional feature macro used by this slice: LCG_MULT_SKIP_ZERO_EN.
package lcg_pkg;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned SHIFT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lcg_mult_step_if.sv
// Request/response bus of the LCG multiply-accumulate step.
//   start  : request, sampled only while busy is low
//   a_in   : multiplier A
//   x_in   : current LCG state x
//   c_in   : increment C
//   busy   : computation in progress
//   done   : one-cycle pulse, result valid
//   result : x_next, held until the next done
interface lcg_mult_step_if;
  import lcg_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a_in, x_in, c_in,
    input  busy, done, result
  );

  modport slave (
    input  start, a_in, x_in, c_in,
    output busy, done, result
  );

endinterface

// File: rtl/Barrel_shifter.sv
// 64-bit logical left barrel shifter used for the partial products.
//   data_in  : value to shift
//   shift    : shift amount, 0..63
//   data_out : data_in << shift, zero filled
module Barrel_shifter (
  input  logic [63:0] data_in,
  input  logic [5:0]  shift,
  output logic [63:0] data_out
);

  // Six log stages, stage s shifts by 2**s when shift[s] is set.
  logic [63:0] stage [0:6];

  assign stage[0] = data_in;

  for (genvar s = 0; s < 6; s++) begin : g_stage
    assign stage[s+1] = shift[s] ? (stage[s] << (1 << s)) : stage[s];
  end

  assign data_out = stage[6];

endmodule

// File: rtl/lcg_lsb_index.sv
// Lowest-set-bit priority encoder, only built when LCG_MULT_SKIP_ZERO_EN is defined.
//   vec  : 64-bit input vector
//   idx  : index of the lowest set bit (0 when vec is all zero)
//   zero : vec is all zero
`ifdef LCG_MULT_SKIP_ZERO_EN
module lcg_lsb_index
  import lcg_pkg::*;
(
  input  logic [WIDTH-1:0]   vec,
  output logic [SHIFT_W-1:0] idx,
  output logic               zero
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = SHIFT_W'(i);
    end
  end

  assign zero = (vec == '0);

endmodule
`endif

// File: rtl/lcg_mult_step.sv
// One LCG step, result = (A*x + C) mod 2^64, by shift-and-add over the bits of A.
// Partial products x<<i come from Barrel_shifter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : start/a_in/x_in/c_in in, busy/done/result out (slave side)
// Macro LCG_MULT_SKIP_ZERO_EN: visit only the set bits of A, latency max(popcount(A),1);
// undefined gives a fixed 64-edge latency. Results are identical in both modes.
module lcg_mult_step
  import lcg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  lcg_mult_step_if.slave  bus
);

  state_t             state, state_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [WIDTH-1:0]   result_q, result_n;
  logic [WIDTH-1:0]   acc, acc_n;
  logic [WIDTH-1:0]   a_reg, a_n;
  logic [WIDTH-1:0]   x_reg, x_n;
  logic [SHIFT_W-1:0] shift_idx;
  logic               bit_set;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   sum;
  logic               last;

`ifdef LCG_MULT_SKIP_ZERO_EN
  // a_reg acts as the remaining-bits mask; each RUN edge consumes its lowest set bit.
  logic             rem_zero;
  logic [WIDTH-1:0] a_clr;

  lcg_lsb_index u_lsb (
    .vec  (a_reg),
    .idx  (shift_idx),
    .zero (rem_zero)
  );

  assign bit_set = ~rem_zero;
  assign a_clr   = a_reg & (a_reg - WIDTH'(1));
  assign last    = (a_clr == '0);
`else
  logic [SHIFT_W-1:0] idx, idx_n;

  assign shift_idx = idx;
  assign bit_set   = a_reg[idx];
  assign last      = (idx == SHIFT_W'(WIDTH - 1));
`endif

  Barrel_shifter u_shift (
    .data_in  (x_reg),
    .shift    (shift_idx),
    .data_out (shifted)
  );

  assign term = bit_set ? shifted : '0;
  assign sum  = acc + term;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc      <= '0;
      a_reg    <= '0;
      x_reg    <= '0;
`ifndef LCG_MULT_SKIP_ZERO_EN
      idx      <= '0;
`endif
    end else begin
      state    <= state_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      result_q <= result_n;
      acc      <= acc_n;
      a_reg    <= a_n;
      x_reg    <= x_n;
`ifndef LCG_MULT_SKIP_ZERO_EN
      idx      <= idx_n;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    busy_n   = busy_q;
    done_n   = 1'b0;
    result_n = result_q;
    acc_n    = acc;
    a_n      = a_reg;
    x_n      = x_reg;
`ifndef LCG_MULT_SKIP_ZERO_EN
    idx_n    = idx;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_n     = bus.a_in;
          x_n     = bus.x_in;
          acc_n   = bus.c_in;
`ifndef LCG_MULT_SKIP_ZERO_EN
          idx_n   = '0;
`endif
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = sum;
`ifdef LCG_MULT_SKIP_ZERO_EN
        a_n   = a_clr;
`else
        idx_n = idx + SHIFT_W'(1);
`endif
        if (last) begin
          result_n = sum;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
